// File: rtl/btn_event_scheduler.sv
// +----------------------------------------------------------------------------+
// | btn_event_scheduler: shared-sampler debounce for NUM_BTN buttons with a     |
// | round-robin valid/ready press-event port. Option: RELEASE_EVT_EN (release). |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module btn_event_scheduler #(
  parameter int NUM_BTN    = 4,
  parameter int ID_W       = 2,
  parameter int SAMPLE_DIV = 100000,
  parameter int CNT_W      = 17,
  parameter int HIST_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic               evt_overflow
`ifdef RELEASE_EVT_EN
  ,
  output logic               evt_release
`endif
);

`ifdef RELEASE_EVT_EN
  localparam int REQ_N = 2 * NUM_BTN;
  localparam int PTR_W = ID_W + 1;
`else
  localparam int REQ_N = NUM_BTN;
  localparam int PTR_W = ID_W;
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [ID_W-1:0]    idx, idx_next;
  logic [CNT_W-1:0]   div;
  logic               tick;
  logic [NUM_BTN-1:0] sync_a, sync_b;
  logic [HIST_W-1:0]  hist [NUM_BTN];
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] pending, pending_next, press_set;
  logic [HIST_W-1:0]  new_hist;
  logic               hist_ones, hist_zeros, scan_en, rise, fall;
  logic [REQ_N-1:0]   req, clr_req;
  logic [PTR_W-1:0]   rr_ptr, grant, ptr_next;
  logic [PTR_W:0]     cand;
  logic               found, load, ovf_set;
  logic [ID_W-1:0]    grant_id;
`ifdef RELEASE_EVT_EN
  logic [NUM_BTN-1:0] rel_pending, rel_pending_next, rel_set, clr_rel;
  logic               grant_rel;
`endif

  assign tick      = (div == CNT_W'(SAMPLE_DIV - 1));
  assign btn_level = level;

  // Sample tick divider, synchronizers and scan state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      div    <= '0;
      state  <= IDLE;
      idx    <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      div    <= tick ? '0 : div + CNT_W'(1);
      state  <= state_next;
      idx    <= idx_next;
    end
  end

  // A tick arriving during SCAN is dropped by construction.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        if (idx == ID_W'(NUM_BTN - 1)) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + ID_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_comb begin
    scan_en    = (state == SCAN);
    new_hist   = {hist[idx][HIST_W-2:0], sync_b[idx]};
    hist_ones  = &new_hist;
    hist_zeros = ~|new_hist;
    rise       = scan_en && hist_ones && !level[idx];
    fall       = scan_en && hist_zeros && level[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hist[i] <= '0;
      end
      level <= '0;
    end else if (scan_en) begin
      hist[idx] <= new_hist;
      if (hist_ones) begin
        level[idx] <= 1'b1;
      end else if (hist_zeros) begin
        level[idx] <= 1'b0;
      end
    end
  end

  // Round-robin search starting at rr_ptr, wrapping over all requests
  always_comb begin
`ifdef RELEASE_EVT_EN
    req = {rel_pending, pending};
`else
    req = pending;
`endif
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < REQ_N; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(REQ_N)) begin
        cand = cand - (PTR_W + 1)'(REQ_N);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        grant = cand[PTR_W-1:0];
      end
    end
    load     = !evt_valid && found;
    ptr_next = (grant == PTR_W'(REQ_N - 1)) ? '0 : grant + PTR_W'(1);
    for (int i = 0; i < REQ_N; i++) begin
      clr_req[i] = load && (grant == PTR_W'(i));
    end
`ifdef RELEASE_EVT_EN
    grant_rel = (grant >= PTR_W'(NUM_BTN));
    grant_id  = grant_rel ? ID_W'(grant - PTR_W'(NUM_BTN)) : ID_W'(grant);
`else
    grant_id  = ID_W'(grant);
`endif
  end

  // Set beats a same-cycle grant clear, and that case is not an overflow.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      press_set[i] = rise && (idx == ID_W'(i));
    end
    pending_next = (pending & ~clr_req[NUM_BTN-1:0]) | press_set;
    ovf_set      = rise && pending[idx] && !clr_req[idx];
`ifdef RELEASE_EVT_EN
    clr_rel = clr_req[REQ_N-1:NUM_BTN];
    for (int i = 0; i < NUM_BTN; i++) begin
      rel_set[i] = fall && (idx == ID_W'(i));
    end
    rel_pending_next = (rel_pending & ~clr_rel) | rel_set;
    ovf_set          = ovf_set || (fall && rel_pending[idx] && !clr_rel[idx]);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      evt_overflow <= 1'b0;
`ifdef RELEASE_EVT_EN
      rel_pending  <= '0;
`endif
    end else begin
      pending <= pending_next;
`ifdef RELEASE_EVT_EN
      rel_pending <= rel_pending_next;
`endif
      if (ovf_set) begin
        evt_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid   <= 1'b0;
      evt_id      <= '0;
      rr_ptr      <= '0;
`ifdef RELEASE_EVT_EN
      evt_release <= 1'b0;
`endif
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_id    <= grant_id;
      rr_ptr    <= ptr_next;
`ifdef RELEASE_EVT_EN
      evt_release <= grant_rel;
`endif
    end
  end

  // fall is consumed only by the release-event path
  logic unused_fall;
  assign unused_fall = fall;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_btn_event_scheduler: directed bench for btn_event_scheduler (4 buttons). |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_btn_event_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready = 1'b0;
  logic       evt_overflow;
  logic       rel_now;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ev_id[$];
  int ev_cyc[$];
  int all_ev[$];
  bit hold_watch = 1'b0;
  int hold_bad = 0;

  btn_event_scheduler #(
    .NUM_BTN(4), .ID_W(2), .SAMPLE_DIV(4), .CNT_W(2), .HIST_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .evt_overflow(evt_overflow)
`ifdef RELEASE_EVT_EN
    ,
    .evt_release(rel_now)
`endif
  );

`ifndef RELEASE_EVT_EN
  assign rel_now = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after posedge, so a negedge view predicts the handshake
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      all_ev.push_back({27'd0, rel_now, 2'b00, evt_id});
      if (!rel_now) begin
        ev_id.push_back(int'(evt_id));
        ev_cyc.push_back(cyc);
      end
    end
    if (hold_watch && !(evt_valid && evt_id == 2'd2)) hold_bad++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_raw = 4'b0;
    evt_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    ev_id.delete();
    ev_cyc.delete();
    all_ev.delete();
  endtask

  task automatic wait_lvl(input int b, input logic v, input string tag);
    int t = 0;
    while (btn_level[b] !== v && t < 300) begin
      step(1);
      t++;
    end
    chk(tag, {31'd0, btn_level[b]}, {31'd0, v});
  endtask

  initial begin
    int lvl_bad;
    int lat;

    step(3);
    chk("rst_level", btn_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_ovf", evt_overflow, 0);
    rst = 1'b0;
    step(2);

    // Bounce: no stable run of 8 ones while toggling
    evt_ready = 1'b1;
    lvl_bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0) btn_raw[0] = ~btn_raw[0];
      step(1);
      if (btn_level[0]) lvl_bad++;
    end
    chk("bnc_level_low", lvl_bad, 0);
    chk("bnc_no_evt", ev_id.size(), 0);
    btn_raw[0] = 1'b1;
    lat = 0;
    while (!btn_level[0] && lat < 200) begin
      step(1);
      lat++;
    end
    chk("bnc_rise", btn_level[0], 1);
    chk("bnc_lat_min", lat >= 32, 1);
    chk("bnc_lat_max", lat <= 80, 1);
    step(40);
    chk("bnc_one_evt", ev_id.size(), 1);
    chk("bnc_id", ev_id.size() > 0 ? ev_id[0] : -1, 0);

    // Simultaneous press of 1 and 3
    do_reset();
    evt_ready = 1'b1;
    btn_raw = 4'b1010;
    wait_lvl(1, 1'b1, "sim_lvl1");
    wait_lvl(3, 1'b1, "sim_lvl3");
    step(20);
    chk("sim_cnt", ev_id.size(), 2);
    chk("sim_id0", ev_id.size() > 0 ? ev_id[0] : -1, 1);
    chk("sim_id1", ev_id.size() > 1 ? ev_id[1] : -1, 3);
    chk("sim_gap", ev_cyc.size() > 1 ? (ev_cyc[1] - ev_cyc[0] >= 2) : 0, 1);
    chk("sim_ovf", evt_overflow, 0);

    // Backpressure on button 2
    do_reset();
    btn_raw[2] = 1'b1;
    wait_lvl(2, 1'b1, "bp_p1");
    step(3);
    chk("bp_valid", evt_valid, 1);
    chk("bp_id", evt_id, 2);
    hold_watch = 1'b1;
    btn_raw[2] = 1'b0;
    wait_lvl(2, 1'b0, "bp_r1");
    btn_raw[2] = 1'b1;
    wait_lvl(2, 1'b1, "bp_p2");
    step(3);
    chk("bp_ovf0", evt_overflow, 0);
    btn_raw[2] = 1'b0;
    wait_lvl(2, 1'b0, "bp_r2");
    btn_raw[2] = 1'b1;
    wait_lvl(2, 1'b1, "bp_p3");
    step(3);
    chk("bp_ovf1", evt_overflow, 1);
    hold_watch = 1'b0;
    chk("bp_hold", hold_bad, 0);
    evt_ready = 1'b1;
    step(20);
    chk("bp_cnt", ev_id.size(), 2);
    chk("bp_id0", ev_id.size() > 0 ? ev_id[0] : -1, 2);
    chk("bp_id1", ev_id.size() > 1 ? ev_id[1] : -1, 2);
    chk("bp_ovf_sticky", evt_overflow, 1);

    // Round robin: pointer past 0 must favour 1 over a waiting 0
    do_reset();
    btn_raw[0] = 1'b1;
    wait_lvl(0, 1'b1, "rr_p0");
    btn_raw[0] = 1'b0;
    wait_lvl(0, 1'b0, "rr_r0");
    btn_raw[1:0] = 2'b11;
    wait_lvl(0, 1'b1, "rr_p0b");
    wait_lvl(1, 1'b1, "rr_p1");
    step(3);
    evt_ready = 1'b1;
    step(20);
    chk("rr_cnt", ev_id.size(), 3);
    chk("rr_id0", ev_id.size() > 0 ? ev_id[0] : -1, 0);
    chk("rr_id1", ev_id.size() > 1 ? ev_id[1] : -1, 1);
    chk("rr_id2", ev_id.size() > 2 ? ev_id[2] : -1, 0);

    // Async reset with a held event, overflow and level set
    do_reset();
    for (int p = 0; p < 3; p++) begin
      btn_raw[3] = 1'b1;
      wait_lvl(3, 1'b1, "ar_press");
      if (p < 2) begin
        btn_raw[3] = 1'b0;
        wait_lvl(3, 1'b0, "ar_release");
      end
    end
    step(3);
    chk("ar_pre_valid", evt_valid, 1);
    chk("ar_pre_ovf", evt_overflow, 1);
    btn_raw = 4'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", evt_valid, 0);
    chk("ar_id", evt_id, 0);
    chk("ar_level", btn_level, 0);
    chk("ar_ovf", evt_overflow, 0);
    step(2);
    rst = 1'b0;
    ev_id.delete();
    all_ev.delete();
    evt_ready = 1'b1;
    step(150);
    chk("ar_no_evt", all_ev.size(), 0);

`ifdef RELEASE_EVT_EN
    do_reset();
    evt_ready = 1'b1;
    btn_raw[3] = 1'b1;
    wait_lvl(3, 1'b1, "rel_press");
    btn_raw[3] = 1'b0;
    wait_lvl(3, 1'b0, "rel_release");
    step(20);
    chk("rel_cnt", all_ev.size(), 2);
    chk("rel_ev0", all_ev.size() > 0 ? all_ev[0] : -1, 32'h3);
    chk("rel_ev1", all_ev.size() > 1 ? all_ev[1] : -1, 32'h13);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
